sc_bitstream_counter: RTL and testbench



---
 rtl/sc_pkg.sv | 39 +++
 rtl/sc_lane_counter.sv | 38 +++
 rtl/sc_bitstream_counter.sv | 122 ++++++++++++
 tb/tb_sc_bitstream_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants, types and bus-packing helpers
// for the stochastic-to-binary bitstream counter.
package sc_pkg;

  localparam int N      = 8;
  localparam int LANES  = 4;
  localparam int WINDOW = 2 ** N;
  localparam int CW     = N + 1;

  typedef logic [N:0]          count_t;
  typedef logic [N-1:0]        cyc_t;
  typedef logic [CW*LANES-1:0] bus_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam cyc_t CYC_LAST = cyc_t'(WINDOW - 1);

  function automatic bus_t lane_put(
    input bus_t   bus,
    input int     idx,
    input count_t val
  );
    bus_t r;
    r = bus;
    r[CW*idx +: CW] = val;
    return r;
  endfunction

  function automatic count_t lane_get(
    input bus_t bus,
    input int   idx
  );
    return bus[CW*idx +: CW];
  endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// One-lane ones counter; clear wins over enable,
// reset wins over both.
module sc_lane_counter
  import sc_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   clear_i,
  input  logic   en_i,
  input  logic   bit_i,
  output count_t count_o
);

  count_t cnt_q;
  count_t cnt_d;

  // next count: clear, accumulate, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + count_t'(bit_i);
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sc_bitstream_counter.sv
// Counts ones per lane over 2^N-clock windows and
// publishes the packed (N+1)-bit lane counts.
module sc_bitstream_counter
  import sc_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cont,
  input  logic [LANES-1:0]         bits_in,
  output logic [(N+1)*LANES-1:0]   out,
  output logic                     out_valid,
  output logic                     busy
);

  state_e state_q;
  state_e state_d;
  cyc_t   cyc_q;
  cyc_t   cyc_d;
  bus_t   out_q;
  bus_t   out_d;
  logic   valid_q;
  logic   win_end;
  logic   lane_clr;
  logic   lane_en;
  count_t cnt [LANES];

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: start leaves IDLE, a non-cont window end returns
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        if (win_end && !cont) state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: lane control, window end and busy
  always_comb begin
    busy     = 1'b0;
    lane_en  = 1'b0;
    lane_clr = 1'b0;
    win_end  = 1'b0;
    unique case (state_q)
      IDLE: begin
        lane_clr = start;
      end
      COUNT: begin
        busy     = 1'b1;
        lane_en  = 1'b1;
        win_end  = (cyc_q == CYC_LAST);
        lane_clr = win_end;
      end
    endcase
  end

  // cycle counter rests at zero in IDLE, wraps in COUNT
  always_comb begin
    cyc_d = '0;
    if (state_q == COUNT) begin
      cyc_d = cyc_q + cyc_t'(1);
    end
  end

  // cycle counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sc_lane_counter u_lane (
      .clock   (clock),
      .reset   (reset),
      .clear_i (lane_clr),
      .en_i    (lane_en),
      .bit_i   (bits_in[i]),
      .count_o (cnt[i])
    );
  end

  // result folds in the final sample so all 2^N are counted
  always_comb begin
    out_d = out_q;
    if (win_end) begin
      for (int i = 0; i < LANES; i++) begin
        out_d = lane_put(out_d, i,
                         cnt[i] + count_t'(bits_in[i]));
      end
    end
  end

  // output register and one-cycle valid pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= win_end;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sc_bitstream_counter.sv
// Directed and random windows checked against a
// column-popcount model of each window's samples.
module tb_sc_bitstream_counter;
  import sc_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   cont;
  logic [LANES-1:0]       bits_in;
  logic [(N+1)*LANES-1:0] out;
  logic                   out_valid;
  logic                   busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [LANES-1:0] win [WINDOW];

  sc_bitstream_counter dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cont      (cont),
    .bits_in   (bits_in),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bus_t model_counts();
    bus_t r;
    int   c;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      c = 0;
      for (int k = 0; k < WINDOW; k++) begin
        c += int'(win[k][l]);
      end
      r[(N+1)*l +: N+1] = c[N:0];
    end
    return r;
  endfunction

  task automatic do_start(
    input logic [LANES-1:0] b0,
    input logic             c0
  );
    start   = 1'b1;
    bits_in = b0;
    cont    = c0;
    tick();
    start = 1'b0;
    chk("start busy", 64'(busy), 64'd1);
    chk("start valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run_window(
    input string tag,
    input logic  cont_v,
    input bit    jitter,
    input int    poke
  );
    bus_t        exp;
    bus_t        prev;
    int          bad_v;
    int          bad_b;
    int          bad_o;
    logic [31:0] r;
    exp   = model_counts();
    prev  = out;
    bad_v = 0;
    bad_b = 0;
    bad_o = 0;
    for (int k = 0; k < WINDOW; k++) begin
      r       = $urandom();
      bits_in = win[k];
      cont    = (jitter && k != WINDOW-1) ? r[0] : cont_v;
      start   = (k == poke);
      tick();
      start = 1'b0;
      if (k != WINDOW-1) begin
        if (out_valid !== 1'b0) bad_v++;
        if (busy !== 1'b1) bad_b++;
        if (out !== prev) bad_o++;
      end
    end
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out"}, 64'(out), 64'(exp));
    chk({tag, " busy"}, 64'(busy), 64'(cont_v));
    chk({tag, " early valid"}, 64'(bad_v), 64'd0);
    chk({tag, " mid busy"}, 64'(bad_b), 64'd0);
    chk({tag, " out moved"}, 64'(bad_o), 64'd0);
  endtask

  task automatic idle_check(input string tag);
    bus_t prev;
    prev = out;
    bits_in = '1;
    cont    = 1'b0;
    tick();
    chk({tag, " idle valid"}, 64'(out_valid), 64'd0);
    chk({tag, " idle busy"}, 64'(busy), 64'd0);
    chk({tag, " idle hold"}, 64'(out), 64'(prev));
  endtask

  task automatic fill_random();
    logic [31:0] r;
    for (int k = 0; k < WINDOW; k++) begin
      r      = $urandom();
      win[k] = r[LANES-1:0];
    end
  endtask

  initial begin
    logic [31:0] r;
    reset   = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    bits_in = '0;
    repeat (3) tick();
    chk("reset out", 64'(out), 64'd0);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle no start", 64'(busy), 64'd0);

    // all ones: every lane reaches the full window
    for (int k = 0; k < WINDOW; k++) win[k] = '1;
    do_start('1, 1'b0);
    run_window("t1", 1'b0, 1'b0, -1);
    for (int l = 0; l < LANES; l++) begin
      chk("t1 lane full", 64'(lane_get(out, l)), 64'h100);
    end
    idle_check("t1");

    // per-lane patterns; ones on start edge ignored
    for (int k = 0; k < WINDOW; k++) begin
      win[k] = {k != WINDOW-1, k < 3, k % 2 == 0, 1'b0};
    end
    do_start('1, 1'b0);
    run_window("t2", 1'b0, 1'b0, -1);
    chk("t2 lane0", 64'(lane_get(out, 0)), 64'd0);
    chk("t2 lane1", 64'(lane_get(out, 1)), 64'd128);
    chk("t2 lane2", 64'(lane_get(out, 2)), 64'd3);
    chk("t2 lane3", 64'(lane_get(out, 3)), 64'd255);
    idle_check("t2");

    // continuous windows back to back, then drop cont
    for (int k = 0; k < WINDOW; k++) win[k] = 4'b0101;
    do_start('0, 1'b1);
    run_window("t3a", 1'b1, 1'b0, -1);
    run_window("t3b", 1'b1, 1'b0, -1);
    chk("t3 lane0", 64'(lane_get(out, 0)), 64'h100);
    chk("t3 lane1", 64'(lane_get(out, 1)), 64'd0);
    run_window("t3c", 1'b0, 1'b0, -1);
    idle_check("t3");

    // reset mid-window discards the partial counts
    do_start('1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      bits_in = '1;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4 rst out", 64'(out), 64'd0);
    chk("t4 rst valid", 64'(out_valid), 64'd0);
    chk("t4 rst busy", 64'(busy), 64'd0);
    bits_in = '0;
    tick();
    chk("t4 stays idle", 64'(busy), 64'd0);
    for (int k = 0; k < WINDOW; k++) win[k] = '1;
    do_start('1, 1'b0);
    run_window("t4", 1'b0, 1'b0, -1);
    idle_check("t4");

    // start pulse mid-window and cont jitter ignored
    fill_random();
    r = $urandom();
    do_start(r[LANES-1:0], 1'b0);
    run_window("t5", 1'b0, 1'b1, 50);
    idle_check("t5");

    // random continuous run with cont jitter
    fill_random();
    r = $urandom();
    do_start(r[LANES-1:0], 1'b1);
    run_window("t6a", 1'b1, 1'b1, -1);
    fill_random();
    run_window("t6b", 1'b1, 1'b1, 17);
    fill_random();
    run_window("t6c", 1'b0, 1'b1, -1);
    idle_check("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
